if_id_hazard: RTL and testbench
===============================

# if_id_hazard

IF/ID pipeline register plus load-use hazard detection for the 5-stage RISC-V core. Sits directly downstream of the fetch stage: captures the fetched PC and instruction each cycle, presents them to decode, and returns `PC_write` to fetch so the PC and this register freeze together on a load-use hazard. Squashes the fetched instruction when a taken branch (`PCSrc`) redirects fetch.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `PC_IF` input XLEN: PC of the instruction being fetched.
- `INSTRUCTION_IF` input XLEN: instruction word from instruction memory.
- `PCSrc` input 1: taken branch/jump redirect; flushes IF/ID.
- `MemRead_EX` input 1: instruction in ID/EX is a load.
- `rd_EX` input 5: destination register of the ID/EX instruction.
- `PC_ID` output XLEN: registered PC for decode.
- `INSTRUCTION_ID` output XLEN: registered instruction for decode.
- `valid_ID` output 1: IF/ID holds a real, unsquashed instruction.
- `rs1_ID`, `rs2_ID`, `rd_ID` output 5 each: fields [19:15], [24:20], [11:7] of `INSTRUCTION_ID`.
- `PC_write` output 1: to fetch; 0 freezes the PC.
- `bubble_ID` output 1: forces decode to zero control signals into ID/EX this cycle.
- `stall_count`, `flush_count` output 32 each: present only with `IF_ID_PERF_EN`.

## Operation
- Reset: `PC_ID`=0, `INSTRUCTION_ID`=32'h00000013 (NOP, `addi x0,x0,0`), `valid_ID`=0, counters 0.
- Source usage from `INSTRUCTION_ID[6:0]`:
  - rs1 used by all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111.
  - rs2 used only by R 0110011, STORE 0100011, BRANCH 1100011.
- Hazard (combinational): `hazard = valid_ID & MemRead_EX & (rd_EX != 0) & ((uses_rs1 & rd_EX==rs1_ID) | (uses_rs2 & rd_EX==rs2_ID))`.
- Per-cycle action, priority order:
  1. `reset`: load reset values.
  2. `PCSrc`=1 (flush): load NOP, `PC_ID`=0, `valid_ID`=0. Flush overrides stall.
  3. `hazard`=1 (stall): hold all IF/ID state.
  4. Otherwise: load `PC_IF`/`INSTRUCTION_IF`, `valid_ID`=1.
- `PC_write = ~(hazard & ~PCSrc)`; `bubble_ID = hazard | ~valid_ID`.
- A stalled instruction re-evaluates next cycle. One bubble clears the hazard because the load has then left ID/EX.
- `rd_EX`=x0 never causes a stall.

## Timing
- Latency IF→ID: 1 cycle.
- `PC_write`, `bubble_ID`, and `rs*`/`rd_ID` are combinational from registered state plus `PCSrc`/`MemRead_EX`/`rd_EX`, so they are valid in the same cycle as the inputs. There is no combinational path from `PC_IF` or `INSTRUCTION_IF` to any output.
- A load-use stall lasts exactly 1 cycle per dependent instruction.
- A flush produces exactly 1 invalid cycle in ID. Back-to-back `PCSrc` gives consecutive invalid cycles.
- `reset` asserted mid-stall: reset values load on that edge, and `PC_write`=1 from the next cycle.

## Configuration
- `IF_ID_PERF_EN` defined:
  - 32-bit `stall_count` increments on each cycle with `hazard & ~PCSrc`.
  - `flush_count` increments on each cycle with `PCSrc`.
  - Both wrap at 2^32 and clear on `reset`.
- `IF_ID_PERF_EN` undefined: counter ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `riscv_pkg`: `NOP_INSTR` = 32'h00000013, opcode constants (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_R`, `OP_STORE`, `OP_BRANCH`, `OP_LOAD`), register-index width 5.
- One sub-module, `hazard_detection_unit`: purely combinational, takes `INSTRUCTION_ID`, `valid_ID`, `MemRead_EX`, `rd_EX` and produces `hazard`. The IF/ID register and counters stay in the top.

## Test plan
- Reset held 2 cycles, then released with `PC_IF`=0x0, instruction 0x00500093 → after 1 edge `PC_ID`=0, `INSTRUCTION_ID`=0x00500093, `valid_ID`=1, `PC_write`=1.
- ID holds `add x3,x1,x2` (0x002081B3), `MemRead_EX`=1, `rd_EX`=2 → `PC_write`=0, `bubble_ID`=1, IF/ID held one edge. Next cycle with `MemRead_EX`=0 → `PC_write`=1 and the instruction advances.
- Same ID instruction, `MemRead_EX`=1, `rd_EX`=0, then `rd_EX`=5 → no stall in either case.
- ID holds `lui x1,0x12345` (0x123450B7), `rd_EX` matches field [19:15] with `MemRead_EX`=1 → no stall, because LUI does not use rs1.
- `hazard` and `PCSrc`=1 in the same cycle → `PC_write`=1, next `INSTRUCTION_ID`=0x00000013, `valid_ID`=0.
- With `IF_ID_PERF_EN`: 3 stall cycles and 2 flush cycles → `stall_count`=3, `flush_count`=2. Then `reset` → both 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the IF/ID stage: NOP encoding, opcodes, register index width.
package riscv_pkg;

  localparam int          REG_W     = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

endpackage

// File: rtl/hazard_detection_unit.sv
// Combinational load-use hazard detection for the instruction sitting in IF/ID.
module hazard_detection_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]  INSTRUCTION_ID,
  input  logic             valid_ID,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] rd_EX,
  output logic             hazard
);

  logic [6:0]       opcode;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             uses_rs1;
  logic             uses_rs2;

  assign opcode = INSTRUCTION_ID[6:0];
  assign rs1    = INSTRUCTION_ID[19:15];
  assign rs2    = INSTRUCTION_ID[24:20];

  // U-type and JAL carry immediate bits where rs1/rs2 would be; never treat them as sources.
  assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign hazard = valid_ID && MemRead_EX && (rd_EX != '0) &&
                  ((uses_rs1 && (rd_EX == rs1)) || (uses_rs2 && (rd_EX == rs2)));

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall and branch flush.
// Optional performance counters are built when IF_ID_PERF_EN is defined.
module if_id_hazard
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PC_IF,
  input  logic [XLEN-1:0]  INSTRUCTION_IF,
  input  logic             PCSrc,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] rd_EX,
  output logic [XLEN-1:0]  PC_ID,
  output logic [XLEN-1:0]  INSTRUCTION_ID,
  output logic             valid_ID,
  output logic [REG_W-1:0] rs1_ID,
  output logic [REG_W-1:0] rs2_ID,
  output logic [REG_W-1:0] rd_ID,
  output logic             PC_write,
`ifdef IF_ID_PERF_EN
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count,
`endif
  output logic             bubble_ID
);

  logic hazard;

  hazard_detection_unit #(.XLEN(XLEN)) u_hdu (
    .INSTRUCTION_ID (INSTRUCTION_ID),
    .valid_ID       (valid_ID),
    .MemRead_EX     (MemRead_EX),
    .rd_EX          (rd_EX),
    .hazard         (hazard)
  );

  // Flush wins over stall: the held instruction is on the wrong path anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_ID          <= '0;
      INSTRUCTION_ID <= XLEN'(NOP_INSTR);
      valid_ID       <= 1'b0;
    end else if (PCSrc) begin
      PC_ID          <= '0;
      INSTRUCTION_ID <= XLEN'(NOP_INSTR);
      valid_ID       <= 1'b0;
    end else if (!hazard) begin
      PC_ID          <= PC_IF;
      INSTRUCTION_ID <= INSTRUCTION_IF;
      valid_ID       <= 1'b1;
    end
  end

  assign rs1_ID    = INSTRUCTION_ID[19:15];
  assign rs2_ID    = INSTRUCTION_ID[24:20];
  assign rd_ID     = INSTRUCTION_ID[11:7];
  assign PC_write  = ~(hazard & ~PCSrc);
  assign bubble_ID = hazard | ~valid_ID;

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (hazard && !PCSrc) stall_count <= stall_count + 32'd1;
      if (PCSrc)            flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed self-checking bench for if_id_hazard (IF_ID_PERF_EN enables the counter test).
module tb_if_id_hazard;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] PC_IF = '0;
  logic [XLEN-1:0] INSTRUCTION_IF = 32'h00000013;
  logic            PCSrc = 1'b0;
  logic            MemRead_EX = 1'b0;
  logic [4:0]      rd_EX = '0;
  logic [XLEN-1:0] PC_ID, INSTRUCTION_ID;
  logic            valid_ID, PC_write, bubble_ID;
  logic [4:0]      rs1_ID, rs2_ID, rd_ID;
`ifdef IF_ID_PERF_EN
  logic [31:0]     stall_count, flush_count;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] ADDI   = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] LUI_X1 = 32'h123450B7;  // lui x1,0x12345
  localparam logic [31:0] NOP    = 32'h00000013;

  if_id_hazard #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .PC_IF          (PC_IF),
    .INSTRUCTION_IF (INSTRUCTION_IF),
    .PCSrc          (PCSrc),
    .MemRead_EX     (MemRead_EX),
    .rd_EX          (rd_EX),
    .PC_ID          (PC_ID),
    .INSTRUCTION_ID (INSTRUCTION_ID),
    .valid_ID       (valid_ID),
    .rs1_ID         (rs1_ID),
    .rs2_ID         (rs2_ID),
    .rd_ID          (rd_ID),
    .PC_write       (PC_write),
`ifdef IF_ID_PERF_EN
    .stall_count    (stall_count),
    .flush_count    (flush_count),
`endif
    .bubble_ID      (bubble_ID)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [31:0] pc, input logic [31:0] instr);
    PCSrc = 1'b0; MemRead_EX = 1'b0; rd_EX = '0;
    PC_IF = pc; INSTRUCTION_IF = instr;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (PC_ID !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC_ID, 32'h0); end
    checks++; if (INSTRUCTION_ID !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", INSTRUCTION_ID, NOP); end
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_ID); end
    checks++; if (bubble_ID !== 1'b1) begin failures++; $display("FAIL reset_bubble got=%b exp=1", bubble_ID); end
    PC_IF = 32'h0; INSTRUCTION_IF = ADDI; reset = 1'b0;
    tick();
    checks++; if (PC_ID !== 32'h0) begin failures++; $display("FAIL first_pc got=%h exp=%h", PC_ID, 32'h0); end
    checks++; if (INSTRUCTION_ID !== ADDI) begin failures++; $display("FAIL first_instr got=%h exp=%h", INSTRUCTION_ID, ADDI); end
    checks++; if (valid_ID !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", valid_ID); end
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL first_pc_write got=%b exp=1", PC_write); end
    checks++; if (rd_ID !== 5'd1) begin failures++; $display("FAIL first_rd got=%0d exp=1", rd_ID); end
  endtask

  task automatic test_load_use_stall();
    load_id(32'h4, ADD_X3);
    checks++; if ({rs1_ID, rs2_ID, rd_ID} !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL add_fields got=%0d/%0d/%0d exp=1/2/3", rs1_ID, rs2_ID, rd_ID); end
    PC_IF = 32'h8; INSTRUCTION_IF = NOP; MemRead_EX = 1'b1; rd_EX = 5'd2;
    #1;
    checks++; if (PC_write !== 1'b0) begin failures++; $display("FAIL stall_pc_write got=%b exp=0", PC_write); end
    checks++; if (bubble_ID !== 1'b1) begin failures++; $display("FAIL stall_bubble got=%b exp=1", bubble_ID); end
    tick();
    checks++; if (PC_ID !== 32'h4) begin failures++; $display("FAIL stall_hold_pc got=%h exp=%h", PC_ID, 32'h4); end
    checks++; if (INSTRUCTION_ID !== ADD_X3) begin failures++; $display("FAIL stall_hold_instr got=%h exp=%h", INSTRUCTION_ID, ADD_X3); end
    MemRead_EX = 1'b0;
    #1;
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL unstall_pc_write got=%b exp=1", PC_write); end
    checks++; if (bubble_ID !== 1'b0) begin failures++; $display("FAIL unstall_bubble got=%b exp=0", bubble_ID); end
    tick();
    checks++; if (PC_ID !== 32'h8) begin failures++; $display("FAIL advance_pc got=%h exp=%h", PC_ID, 32'h8); end
    // rs1 dependence also stalls
    load_id(32'h10, ADD_X3);
    MemRead_EX = 1'b1; rd_EX = 5'd1;
    #1;
    checks++; if (PC_write !== 1'b0) begin failures++; $display("FAIL stall_rs1_pc_write got=%b exp=0", PC_write); end
  endtask

  task automatic test_no_stall_cases();
    load_id(32'hC, ADD_X3);
    MemRead_EX = 1'b1; rd_EX = 5'd0;
    #1;
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL x0_pc_write got=%b exp=1", PC_write); end
    rd_EX = 5'd5;
    #1;
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL rd5_pc_write got=%b exp=1", PC_write); end
    checks++; if (bubble_ID !== 1'b0) begin failures++; $display("FAIL rd5_bubble got=%b exp=0", bubble_ID); end
    MemRead_EX = 1'b0; rd_EX = 5'd2;
    #1;
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL noload_pc_write got=%b exp=1", PC_write); end
  endtask

  task automatic test_lui_no_rs();
    load_id(32'h20, LUI_X1);
    checks++; if (rs1_ID !== 5'd8) begin failures++; $display("FAIL lui_rs1_field got=%0d exp=8", rs1_ID); end
    MemRead_EX = 1'b1; rd_EX = 5'd8;
    #1;
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL lui_rs1_pc_write got=%b exp=1", PC_write); end
    rd_EX = 5'd3;
    #1;
    checks++; if (bubble_ID !== 1'b0) begin failures++; $display("FAIL lui_rs2_bubble got=%b exp=0", bubble_ID); end
  endtask

  task automatic test_flush_over_stall();
    load_id(32'h30, ADD_X3);
    MemRead_EX = 1'b1; rd_EX = 5'd2; PCSrc = 1'b1;
    PC_IF = 32'h34; INSTRUCTION_IF = ADDI;
    #1;
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL flush_pc_write got=%b exp=1", PC_write); end
    tick();
    checks++; if (INSTRUCTION_ID !== NOP) begin failures++; $display("FAIL flush_instr got=%h exp=%h", INSTRUCTION_ID, NOP); end
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_ID); end
    checks++; if (PC_ID !== 32'h0) begin failures++; $display("FAIL flush_pc got=%h exp=%h", PC_ID, 32'h0); end
    PCSrc = 1'b0; MemRead_EX = 1'b0;
    tick();
    checks++; if (INSTRUCTION_ID !== ADDI || valid_ID !== 1'b1) begin failures++; $display("FAIL post_flush got=%h/%b exp=%h/1", INSTRUCTION_ID, valid_ID, ADDI); end
  endtask

  task automatic test_back_to_back_flush();
    load_id(32'h40, ADD_X3);
    PCSrc = 1'b1;
    tick();
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL b2b_flush1_valid got=%b exp=0", valid_ID); end
    tick();
    checks++; if (valid_ID !== 1'b0) begin failures++; $display("FAIL b2b_flush2_valid got=%b exp=0", valid_ID); end
    checks++; if (bubble_ID !== 1'b1) begin failures++; $display("FAIL b2b_bubble got=%b exp=1", bubble_ID); end
    PCSrc = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    load_id(32'h50, ADD_X3);
    MemRead_EX = 1'b1; rd_EX = 5'd2;
    #1;
    checks++; if (PC_write !== 1'b0) begin failures++; $display("FAIL midstall_pre got=%b exp=0", PC_write); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (INSTRUCTION_ID !== NOP || valid_ID !== 1'b0) begin failures++; $display("FAIL midstall_reset got=%h/%b exp=%h/0", INSTRUCTION_ID, valid_ID, NOP); end
    checks++; if (PC_write !== 1'b1) begin failures++; $display("FAIL midstall_pc_write got=%b exp=1", PC_write); end
    MemRead_EX = 1'b0;
  endtask

`ifdef IF_ID_PERF_EN
  task automatic test_perf_counters();
    reset = 1'b1; tick(); reset = 1'b0;
    load_id(32'h60, ADD_X3);
    MemRead_EX = 1'b1; rd_EX = 5'd2;
    tick(); tick(); tick();
    MemRead_EX = 1'b0; PCSrc = 1'b1;
    tick(); tick();
    PCSrc = 1'b0;
    checks++; if (stall_count !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", stall_count); end
    checks++; if (flush_count !== 32'd2) begin failures++; $display("FAIL flush_count got=%0d exp=2", flush_count); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin failures++; $display("FAIL counters_reset got=%0d/%0d exp=0/0", stall_count, flush_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use_stall();
    test_no_stall_cases();
    test_lui_no_rs();
    test_flush_over_stall();
    test_back_to_back_flush();
    test_reset_mid_stall();
`ifdef IF_ID_PERF_EN
    test_perf_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
